square_wave_synthesizer: RTL and testbench
==========================================

SQUARE_WAVE_SYNTHESIZER -- requirements
Module: square_wave_synthesizer

Interface
REQ-001 Parameter CLOCK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter NOTE_COUNT, default 36, number of valid note indices (0..NOTE_COUNT-1).
REQ-003 clock  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frequency_select  input  32  note index from the sound sequencer; any value >= NOTE_COUNT (incl. all-ones) means silence.
REQ-006 audio_pwm  output  1  square-wave speaker drive.
REQ-007 audio_sd  output  1  amplifier enable; 1 while playing.
REQ-008 playing  output  1  status; high in PLAY state.

Function
REQ-009 frequency_select SHALL be registered into sel_q every cycle; all decisions use sel_q (1-cycle input latency).
REQ-010 Note i frequency SHALL be NOTE_HZ[i] = round(261.63 * 2^(i/12)) Hz (index 0 = 262 Hz, 9 = 440 Hz, 35 = 1976 Hz).
REQ-011 Half-period count SHALL be HALF[i] = floor(CLOCK_HZ / (2*NOTE_HZ[i])), computed at elaboration; no runtime divider.
REQ-012 Counter width SHALL be $clog2(HALF[0]+1) bits (lowest note gives largest count).
REQ-013 State machine SHALL have two states: IDLE, PLAY.
REQ-014 IDLE: audio_pwm=0, audio_sd=0, playing=0, counter=0.
REQ-015 IDLE->PLAY when sel_q < NOTE_COUNT; first PLAY cycle drives audio_pwm=1, counter=0, latches half_q=HALF[sel_q].
REQ-016 PLAY: counter increments each cycle; when counter==half_q-1, audio_pwm toggles, counter=0, half_q reloads from current sel_q.
REQ-017 A note change in PLAY (valid->different valid) SHALL take effect only at the next toggle boundary; no truncated half-periods.
REQ-018 PLAY->IDLE when sel_q >= NOTE_COUNT, in the same cycle, without waiting for a boundary; audio_pwm forced 0 next cycle.
REQ-019 Silent->valid->silent pulses of one cycle SHALL enter PLAY for exactly one cycle (no latching of stale notes).
REQ-020 Outputs SHALL be registered; no combinational path from frequency_select to any output.
REQ-021 Upper 32-bit compare SHALL be unsigned; values 36..2^32-1 are all silence.

Reset
REQ-022 reset SHALL asynchronously force IDLE, sel_q=all-ones, counter=0, half_q=0, audio_pwm=0, audio_sd=0, playing=0.
REQ-023 reset asserted mid-note SHALL silence output immediately; after deassertion, playback restarts per REQ-015 with phase reset.

Structure
REQ-024 NOTE_HZ table, NOTE_COUNT and silence encoding (all-ones) SHALL live in shared package audio_pkg, also used by the sound sequencer.
REQ-025 One sub-module, half_period_counter (load, enable, terminal pulse), SHALL hold the counter/compare; the FSM stays in the top.

Verification (CLOCK_HZ=1_000_000)
REQ-026 Reset then frequency_select=9 -> playing rises 2 cycles later; audio_pwm toggles every 1136 cycles (440 Hz).
REQ-027 frequency_select=0 then 35 mid-half-period -> current 1908-cycle half completes, following halves are 253 cycles.
REQ-028 PLAY on 9, frequency_select=32'hFFFF_FFFF -> playing=0, audio_sd=0, audio_pwm=0 within 2 cycles; value 36 behaves the same.
REQ-029 reset pulsed mid-note -> all outputs 0 asynchronously; after release with select=35, first half-period is exactly 253 cycles.
REQ-030 Replay sequencer pattern {0,35} with ~0 gaps -> each note starts at audio_pwm=1, no half-period shorter than HALF of active note.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg -- definitions shared by the square-wave synthesizer and the
// sound sequencer that drives it.
//   NOTE_COUNT  : number of playable note indices (0..NOTE_COUNT-1)
//   SILENCE     : canonical "no note" code on the note-select bus
//   NOTE_HZ     : note frequencies, round(261.63 * 2^(i/12)) Hz
//   half_period : clock cycles per half wave of a note, evaluated at
//                 elaboration time only
package audio_pkg;

  localparam int          NOTE_COUNT = 36;
  localparam logic [31:0] SILENCE    = 32'hFFFF_FFFF;

  // Three octaves upward from C4.
  localparam int NOTE_HZ [NOTE_COUNT] = '{
     262,  277,  294,  311,  330,  349,  370,  392,  415,  440,  466,  494,
     523,  554,  587,  622,  659,  698,  740,  784,  831,  880,  932,  988,
    1047, 1109, 1175, 1245, 1319, 1397, 1480, 1568, 1661, 1760, 1865, 1976
  };

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } synth_state_t;

  // Control bundle from the synthesizer FSM to its half-period counter.
  typedef struct packed {
    logic clear;   // park the counter: count=0, half=0
    logic load;    // start a new half period with a freshly selected length
    logic enable;  // advance within the current half period
  } counter_ctl_t;

  function automatic int half_period(input int clock_hz, input int idx);
    return clock_hz / (2 * NOTE_HZ[idx]);
  endfunction

  // The lowest note has the longest half period, so it sizes the counter.
  function automatic int counter_width(input int clock_hz);
    return $clog2(half_period(clock_hz, 0) + 1);
  endfunction

endpackage

// File: rtl/half_period_counter.sv
// half_period_counter -- counts clock cycles within one half wave.
//   clock    : system clock
//   reset    : asynchronous, active-high
//   clear    : force count and latched length to zero (idle)
//   load     : restart at count 0 with length = half
//   enable   : increment count
//   half     : half-period length to latch on load
//   terminal : high while count sits on the last cycle of the half period
// Priority is clear > load > enable. The owner is expected to assert load
// on terminal, so count never runs past half-1.
module half_period_counter #(
  parameter int WIDTH = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] half,
  output logic             terminal
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] half_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      half_q <= '0;
    end else if (clear) begin
      count  <= '0;
      half_q <= '0;
    end else if (load) begin
      count  <= '0;
      half_q <= half;
    end else if (enable) begin
      count  <= count + WIDTH'(1);
    end
  end

  assign terminal = (count == half_q - WIDTH'(1));

endmodule

// File: rtl/square_wave_synthesizer.sv
// square_wave_synthesizer -- turns a note index from the sound sequencer
// into a square wave for a speaker amplifier.
//   clock            : system clock, CLOCK_HZ
//   reset            : asynchronous, active-high
//   frequency_select : note index; any value >= NOTE_COUNT is silence
//   audio_pwm        : square-wave speaker drive
//   audio_sd         : amplifier enable, high while playing
//   playing          : status, high in PLAY
// The select is registered once (sel_q) and every decision uses sel_q.
// A note change while playing waits for the next toggle so no half period
// is ever cut short; silence stops the output immediately.
module square_wave_synthesizer #(
  parameter int CLOCK_HZ   = 100_000_000,
  parameter int NOTE_COUNT = audio_pkg::NOTE_COUNT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] frequency_select,
  output logic        audio_pwm,
  output logic        audio_sd,
  output logic        playing
);

  import audio_pkg::*;

  // The frequency table only covers the package's notes.
  localparam int NOTES = (NOTE_COUNT < audio_pkg::NOTE_COUNT) ? NOTE_COUNT
                                                              : audio_pkg::NOTE_COUNT;
  localparam int CW    = counter_width(CLOCK_HZ);

  synth_state_t state, state_next;
  counter_ctl_t ctl;
  logic [31:0]  sel_q;
  logic         sel_valid;
  logic [CW-1:0] half_tab [NOTES];
  logic [CW-1:0] half_sel;
  logic          terminal;
  logic          pwm_next;

  // Half-period lengths are constants; no divider is built.
  for (genvar i = 0; i < NOTES; i++) begin : g_half
    assign half_tab[i] = CW'(half_period(CLOCK_HZ, i));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sel_q <= SILENCE;
    else       sel_q <= frequency_select;
  end

  // Unsigned compare: everything from NOTES up to all-ones is silence.
  assign sel_valid = (sel_q < 32'(NOTES));

  // Table lookup by full-width equality so out-of-range codes select nothing.
  always_comb begin
    half_sel = '0;
    for (int i = 0; i < NOTES; i++)
      if (sel_q == 32'(i)) half_sel = half_tab[i];
  end

  half_period_counter #(.WIDTH(CW)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (ctl.clear),
    .load     (ctl.load),
    .enable   (ctl.enable),
    .half     (half_sel),
    .terminal (terminal)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sel_valid)  state_next = PLAY;
      PLAY:    if (!sel_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter control and next wave level
  always_comb begin
    ctl      = '0;
    pwm_next = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          // New note always starts high with a fresh phase.
          ctl.load = 1'b1;
          pwm_next = 1'b1;
        end else begin
          ctl.clear = 1'b1;
        end
      end
      PLAY: begin
        if (!sel_valid) begin
          ctl.clear = 1'b1;
        end else if (terminal) begin
          // Boundary: flip and pick up whatever note is selected now.
          ctl.load = 1'b1;
          pwm_next = ~audio_pwm;
        end else begin
          ctl.enable = 1'b1;
          pwm_next   = audio_pwm;
        end
      end
      default: ctl.clear = 1'b1;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      audio_pwm <= 1'b0;
      audio_sd  <= 1'b0;
      playing   <= 1'b0;
    end else begin
      audio_pwm <= pwm_next;
      audio_sd  <= (state_next == PLAY);
      playing   <= (state_next == PLAY);
    end
  end

endmodule

// File: tb/tb_square_wave_synthesizer.sv
module tb_square_wave_synthesizer;

  localparam int CLK_HZ = 1_000_000;
  localparam int NOTES  = 36;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] frequency_select = 32'hFFFF_FFFF;
  logic        audio_pwm, audio_sd, playing;

  square_wave_synthesizer #(.CLOCK_HZ(CLK_HZ), .NOTE_COUNT(NOTES)) dut (
    .clock            (clock),
    .reset            (reset),
    .frequency_select (frequency_select),
    .audio_pwm        (audio_pwm),
    .audio_sd         (audio_sd),
    .playing          (playing)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int ref_half [NOTES];

  // Reference: a note is "a level held for a number of cycles".
  // m_rem counts down the cycles left at the current level.
  logic [31:0] m_sel;
  logic        m_play, m_lvl;
  int          m_rem;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sel <= 32'hFFFF_FFFF; m_play <= 1'b0; m_lvl <= 1'b0; m_rem <= 0;
    end else begin
      if (m_sel >= 32'(NOTES)) begin
        m_play <= 1'b0; m_lvl <= 1'b0; m_rem <= 0;
      end else if (!m_play) begin
        m_play <= 1'b1; m_lvl <= 1'b1; m_rem <= ref_half[int'(m_sel)];
      end else if (m_rem == 1) begin
        m_lvl <= ~m_lvl; m_rem <= ref_half[int'(m_sel)];
      end else begin
        m_rem <= m_rem - 1;
      end
      m_sel <= frequency_select;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle, sampled on the falling edge, compared against the model.
  task automatic tick();
    @(negedge clock);
    check("model_playing", {31'd0, playing},   {31'd0, m_play});
    check("model_sd",      {31'd0, audio_sd},  {31'd0, m_play});
    check("model_pwm",     {31'd0, audio_pwm}, {31'd0, m_lvl});
  endtask

  // Cycles until audio_pwm changes; an expired bound is a failure.
  task automatic wait_toggle(input string name, input int limit, output int n);
    logic lvl;
    lvl = audio_pwm;
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (audio_pwm !== lvl) break;
    end
    if (audio_pwm === lvl) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] sel;
    int          cyc;
    logic        exp_play;
    logic        exp_pwm;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < NOTES; i++) begin
      real hz;
      hz = 261.63 * $pow(2.0, i / 12.0);
      ref_half[i] = CLK_HZ / (2 * $rtoi(hz + 0.5));
    end

    // Expected outputs after holding sel for cyc cycles (hand-derived).
    vecs.push_back('{32'hFFFF_FFFF,    3, 1'b0, 1'b0}); // reset state
    vecs.push_back('{32'd9,            1, 1'b0, 1'b0}); // sel_q just loaded
    vecs.push_back('{32'd9,            1, 1'b1, 1'b1}); // first PLAY cycle
    vecs.push_back('{32'd9,         1135, 1'b1, 1'b1}); // last high cycle
    vecs.push_back('{32'd9,            1, 1'b1, 1'b0}); // toggle at 1136
    vecs.push_back('{32'd9,         1135, 1'b1, 1'b0});
    vecs.push_back('{32'd9,            1, 1'b1, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF,    1, 1'b1, 1'b1}); // latency of silence
    vecs.push_back('{32'hFFFF_FFFF,    1, 1'b0, 1'b0});
    vecs.push_back('{32'd9,            2, 1'b1, 1'b1});
    vecs.push_back('{32'd36,           1, 1'b1, 1'b1});
    vecs.push_back('{32'd36,           1, 1'b0, 1'b0}); // 36 is silence
    vecs.push_back('{32'h8000_0000,    2, 1'b0, 1'b0}); // unsigned compare
    vecs.push_back('{32'd100,          2, 1'b0, 1'b0});
    vecs.push_back('{32'd35,           2, 1'b1, 1'b1});
    vecs.push_back('{32'd35,         252, 1'b1, 1'b1});
    vecs.push_back('{32'd35,           1, 1'b1, 1'b0}); // 253-cycle half
    vecs.push_back('{32'hFFFF_FFFF,    2, 1'b0, 1'b0});
    vecs.push_back('{32'd5,            1, 1'b0, 1'b0}); // one-cycle pulse
    vecs.push_back('{32'hFFFF_FFFF,    1, 1'b1, 1'b1}); // exactly one PLAY cycle
    vecs.push_back('{32'hFFFF_FFFF,    1, 1'b0, 1'b0});

    repeat (3) tick();
    reset = 1'b0;

    foreach (vecs[k]) begin
      frequency_select = vecs[k].sel;
      repeat (vecs[k].cyc) tick();
      check($sformatf("vec%0d_playing", k), {31'd0, playing},   {31'd0, vecs[k].exp_play});
      check($sformatf("vec%0d_sd", k),      {31'd0, audio_sd},  {31'd0, vecs[k].exp_play});
      check($sformatf("vec%0d_pwm", k),     {31'd0, audio_pwm}, {31'd0, vecs[k].exp_pwm});
    end

    // Note change mid half period: the 1908-cycle half completes first.
    frequency_select = 32'd0;
    wait_toggle("chg_start", 10, n);
    check("chg_start_latency", n, 2);
    repeat (500) tick();
    frequency_select = 32'd35;
    wait_toggle("chg_first", 3000, n);
    check("chg_first_half", 500 + n, 1908);
    wait_toggle("chg_second", 400, n);
    check("chg_second_half", n, 253);
    wait_toggle("chg_third", 400, n);
    check("chg_third_half", n, 253);
    frequency_select = 32'hFFFF_FFFF;
    repeat (2) tick();
    check("chg_silent_pwm", {31'd0, audio_pwm}, 32'd0);

    // Reset in the middle of a note.
    frequency_select = 32'd9;
    wait_toggle("rst_start", 10, n);
    repeat (300) tick();
    #2 reset = 1'b1;
    #1;
    check("rst_async_playing", {31'd0, playing},   32'd0);
    check("rst_async_sd",      {31'd0, audio_sd},  32'd0);
    check("rst_async_pwm",     {31'd0, audio_pwm}, 32'd0);
    frequency_select = 32'd35;
    repeat (3) tick();
    reset = 1'b0;
    wait_toggle("rst_restart", 10, n);
    check("rst_restart_latency", n, 2);
    wait_toggle("rst_first_half", 400, n);
    check("rst_first_half", n, 253);

    // Sequencer-like replay: notes with short silent gaps, or none at all.
    for (int r = 0; r < 25; r++) begin
      int pick;
      pick = $urandom_range(0, 3);
      case (pick)
        0:       frequency_select = 32'd0;
        1:       frequency_select = 32'd35;
        2:       frequency_select = $urandom_range(0, NOTES - 1);
        default: frequency_select = $urandom | 32'd36;
      endcase
      repeat ($urandom_range(1, 1200)) tick();
      frequency_select = 32'hFFFF_FFFF;
      repeat ($urandom_range(0, 3)) tick();
    end
    frequency_select = 32'hFFFF_FFFF;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
